// File: rtl/combo_pkg.sv
// Shared types and constants for the keypad combination checker.
package combo_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } combo_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t NO_KEY = 4'hF;

endpackage

// File: rtl/key_edge_detect.sv
// Turns the debounced single-key flag into a one-cycle strobe on its rising edge,
// so a held key yields exactly one digit.
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic one_press,
    output logic press_stb
);

    logic prev_press;

    // Updated in every FSM state so a key held across a state change never re-fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_press <= 1'b0;
        end else begin
            prev_press <= one_press;
        end
    end

    assign press_stb = one_press & ~prev_press;

endmodule

// File: rtl/combo_checker.sv
// Combination-entry FSM: collects BCD digits on key presses, unlocks on a match,
// and enforces a timed lockout after repeated failures.
module combo_checker
    import combo_pkg::*;
#(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
    parameter int                    MAX_ATTEMPTS   = 3,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 500_000_000,
    parameter int                    TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [3:0]                        bcd,
    input  logic                              one_press,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic                              entry_error,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);

    localparam int DW      = $clog2(CODE_LEN + 1);
    localparam int FW      = $clog2(MAX_ATTEMPTS + 1);
    localparam int MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CYC = (MAX_UL > TIMEOUT_CYCLES) ? MAX_UL : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    combo_state_t          state;
    logic                  mismatch;
    logic [TW-1:0]         timer;
    logic                  press_stb;
    logic [4*CODE_LEN-1:0] code_shift;
    bcd_digit_t            exp_digit;
    logic                  digit_ok;
    logic                  last_digit;
    logic                  entry_match;
    logic [FW-1:0]         fail_next;

    key_edge_detect u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .one_press (one_press),
        .press_stb (press_stb)
    );

    // Expected digit is the nibble at position digit_count, counted from the MSB.
    assign code_shift  = CODE >> (4 * (CODE_LEN - 1 - int'(digit_count)));
    assign exp_digit   = code_shift[3:0];
    assign digit_ok    = (bcd != NO_KEY) && (bcd <= 4'd9) && (bcd == exp_digit);
    assign last_digit  = (digit_count == DW'(CODE_LEN - 1));
    assign entry_match = ~mismatch & digit_ok;
    assign fail_next   = fail_count + 1'b1;

    // One down-counter serves as idle timer in ENTRY and hold timer elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTRY;
            digit_count <= '0;
            fail_count  <= '0;
            mismatch    <= 1'b0;
            timer       <= '0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            entry_error <= 1'b0;
            case (state)
                ENTRY: begin
                    if (press_stb) begin
                        timer <= TW'(TIMEOUT_CYCLES - 1);
                        if (last_digit) begin
                            digit_count <= '0;
                            mismatch    <= 1'b0;
                            if (entry_match) begin
                                state      <= UNLOCKED;
                                unlocked   <= 1'b1;
                                fail_count <= '0;
                                timer      <= TW'(UNLOCK_CYCLES - 1);
                            end else begin
                                entry_error <= 1'b1;
                                fail_count  <= fail_next;
                                if (fail_next == FW'(MAX_ATTEMPTS)) begin
                                    state      <= LOCKOUT;
                                    locked_out <= 1'b1;
                                    timer      <= TW'(LOCKOUT_CYCLES - 1);
                                end
                            end
                        end else begin
                            digit_count <= digit_count + 1'b1;
                            mismatch    <= mismatch | ~digit_ok;
                        end
                    end else if (digit_count != '0) begin
                        if (timer == '0) begin
                            digit_count <= '0;
                            mismatch    <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                UNLOCKED: begin
                    if (timer == '0) begin
                        state    <= ENTRY;
                        unlocked <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= ENTRY;
                        locked_out <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= ENTRY;
                    unlocked   <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_checker.sv
// Directed bench for combo_checker with short timers (unlock 8, lockout 16, timeout 20).
module tb_combo_checker;
    import combo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] bcd;
    logic       one_press;
    logic       unlocked;
    logic       locked_out;
    logic       entry_error;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int checks   = 0;
    int failures = 0;

    combo_checker #(
        .CODE_LEN       (4),
        .CODE           (16'h1234),
        .MAX_ATTEMPTS   (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd         (bcd),
        .one_press   (one_press),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .entry_error (entry_error),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    // Rising edge is sampled on the next clock; returns 1 time unit after that edge.
    task automatic key_down(input logic [3:0] d);
        bcd       = d;
        one_press = 1'b1;
        tick();
    endtask

    task automatic key_up();
        one_press = 1'b0;
        bcd       = NO_KEY;
    endtask

    task automatic press(input logic [3:0] d);
        key_down(d);
        wait_n(4);
        key_up();
        wait_n(3);
    endtask

    task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a);
        press(b);
        press(c);
    endtask

    initial begin
        int cnt;
        int bad;

        rst_n     = 1'b0;
        one_press = 1'b0;
        bcd       = NO_KEY;
        wait_n(3);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_locked_out", locked_out, 0);
        chk("rst_entry_error", entry_error, 0);
        chk("rst_digit_count", digit_count, 0);
        chk("rst_fail_count", fail_count, 0);
        rst_n = 1'b1;
        wait_n(2);

        // Correct entry 1,2,3,4
        for (int i = 1; i <= 3; i++) begin
            key_down(4'(i));
            chk("ok_digit_count", digit_count, i);
            wait_n(4);
            key_up();
            wait_n(3);
        end
        key_down(4'd4);
        chk("ok_unlocked_first", unlocked, 1);
        chk("ok_digit_count_clr", digit_count, 0);
        chk("ok_fail_count", fail_count, 0);
        key_up();
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (unlocked) cnt++;
        end
        chk("ok_unlock_len", cnt, 8);

        // Held key times out after 20 cycles, no error
        key_down(4'd1);
        chk("held_digit_count", digit_count, 1);
        cnt = 0;
        bad = 0;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (entry_error) cnt++;
            if (i == 19) chk("held_before_timeout", digit_count, 1);
            if (i == 20) chk("held_after_timeout", digit_count, 0);
            if (i > 20 && digit_count != 0) bad++;
        end
        chk("held_no_error", cnt, 0);
        chk("held_stays_zero", bad, 0);
        key_up();
        wait_n(3);

        // Three wrong entries 1,2,3,5
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd5);
        chk("wrong1_error", entry_error, 1);
        chk("wrong1_fail", fail_count, 1);
        chk("wrong1_digit_count", digit_count, 0);
        key_up();
        tick();
        chk("wrong1_error_pulse", entry_error, 0);
        wait_n(2);
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd5);
        chk("wrong2_error", entry_error, 1);
        chk("wrong2_fail", fail_count, 2);
        chk("wrong2_locked", locked_out, 0);
        key_up();
        wait_n(3);
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd5);
        chk("wrong3_error", entry_error, 1);
        chk("wrong3_locked", locked_out, 1);
        chk("wrong3_fail", fail_count, 3);
        key_up();
        cnt = 1;
        bad = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) begin
                bcd       = 4'd1;
                one_press = 1'b1;
            end
            if (i == 6) key_up();
            tick();
            if (locked_out) cnt++;
            if (digit_count != 0 || unlocked) bad++;
        end
        chk("lockout_len", cnt, 16);
        chk("lockout_ignores_keys", bad, 0);
        chk("lockout_fail_cleared", fail_count, 0);

        // Failure then success
        enter3(4'd9, 4'd9, 4'd9);
        key_down(4'd9);
        chk("ff_fail1", fail_count, 1);
        chk("ff_error", entry_error, 1);
        key_up();
        wait_n(3);
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd4);
        chk("ff_unlocked", unlocked, 1);
        chk("ff_fail0", fail_count, 0);
        key_up();
        wait_n(10);
        chk("ff_relocked", unlocked, 0);

        // Final digit on the exact cycle the idle timeout would fire
        press(4'd1);
        press(4'd2);
        key_down(4'd3);
        key_up();
        wait_n(19);
        chk("sim_pending", digit_count, 3);
        key_down(4'd4);
        chk("sim_unlocked", unlocked, 1);
        chk("sim_no_error", entry_error, 0);
        key_up();
        wait_n(10);

        // Reset in the middle of a lockout
        enter3(4'd1, 4'd2, 4'd3);
        press(4'd6);
        enter3(4'd1, 4'd2, 4'd3);
        press(4'd6);
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd6);
        key_up();
        wait_n(4);
        chk("rl_locked_before", locked_out, 1);
        rst_n = 1'b0;
        #1;
        chk("rl_locked_out", locked_out, 0);
        chk("rl_fail_count", fail_count, 0);
        chk("rl_entry_error", entry_error, 0);
        chk("rl_unlocked", unlocked, 0);
        chk("rl_digit_count", digit_count, 0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(2);
        enter3(4'd1, 4'd2, 4'd3);
        key_down(4'd4);
        chk("rl_unlock_after", unlocked, 1);
        key_up();
        wait_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
